// File: rtl/riscv_pkg.sv
// Shared types and widths for the RV32I execute stage: ALU op codes, forwarding selects
// and the EX/MEM pipeline register layout.
package riscv_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned REG_AW = 5;

  typedef enum logic [2:0] {
    ADD = 3'b000,
    SUB = 3'b001,
    AND = 3'b010,
    OR  = 3'b011,
    XOR = 3'b100,
    SLT = 3'b101,
    SLL = 3'b110,
    SRL = 3'b111
  } alu_ctrl_t;

  typedef enum logic [1:0] {
    FwdRd  = 2'b00,
    FwdW   = 2'b01,
    FwdM   = 2'b10,
    FwdRd2 = 2'b11
  } fwd_sel_t;

  typedef struct packed {
    logic              valid;
    logic              reg_write;
    logic              mem_write;
    logic [1:0]        result_src;
    logic [XLEN-1:0]   alu_result;
    logic [XLEN-1:0]   write_data;
    logic [XLEN-1:0]   pc_plus4;
    logic [REG_AW-1:0] rd;
  } exmem_t;

  // Code 11 is unused by the hazard unit and falls back to the register-file value.
  function automatic logic [XLEN-1:0] fwd_mux(input fwd_sel_t sel, input logic [XLEN-1:0] rd,
                                              input logic [XLEN-1:0] w,
                                              input logic [XLEN-1:0] m);
    case (sel)
      FwdW:    return w;
      FwdM:    return m;
      default: return rd;
    endcase
  endfunction

endpackage

// File: rtl/ex_stage_if.sv
// ID/EX inputs, hazard controls and EX/MEM outputs of the execute stage.
// master drives the stage inputs; slave is the ex_stage side.
interface ex_stage_if;
  import riscv_pkg::*;

  logic              stall;
  logic              flush;
  logic              valid_e;
  logic [XLEN-1:0]   rd1_e;
  logic [XLEN-1:0]   rd2_e;
  logic [XLEN-1:0]   imm_ext_e;
  logic [XLEN-1:0]   pc_e;
  logic [XLEN-1:0]   pc_plus4_e;
  logic [REG_AW-1:0] rd_e;
  logic [2:0]        alu_control;
  logic              alu_src_e;
  logic              reg_write_e;
  logic              mem_write_e;
  logic [1:0]        result_src_e;
  logic              branch_e;
  logic              jump_e;
  logic [1:0]        forward_a_e;
  logic [1:0]        forward_b_e;
  logic [XLEN-1:0]   result_w;

  logic              pc_src_e;
  logic [XLEN-1:0]   pc_target_e;
  logic              valid_m;
  logic              reg_write_m;
  logic              mem_write_m;
  logic [1:0]        result_src_m;
  logic [XLEN-1:0]   alu_result_m;
  logic [XLEN-1:0]   write_data_m;
  logic [XLEN-1:0]   pc_plus4_m;
  logic [REG_AW-1:0] rd_m;

  modport master (
    output stall, flush, valid_e, rd1_e, rd2_e, imm_ext_e, pc_e, pc_plus4_e, rd_e, alu_control,
           alu_src_e, reg_write_e, mem_write_e, result_src_e, branch_e, jump_e, forward_a_e,
           forward_b_e, result_w,
    input  pc_src_e, pc_target_e, valid_m, reg_write_m, mem_write_m, result_src_m,
           alu_result_m, write_data_m, pc_plus4_m, rd_m
  );

  modport slave (
    input  stall, flush, valid_e, rd1_e, rd2_e, imm_ext_e, pc_e, pc_plus4_e, rd_e, alu_control,
           alu_src_e, reg_write_e, mem_write_e, result_src_e, branch_e, jump_e, forward_a_e,
           forward_b_e, result_w,
    output pc_src_e, pc_target_e, valid_m, reg_write_m, mem_write_m, result_src_m,
           alu_result_m, write_data_m, pc_plus4_m, rd_m
  );

endinterface

// File: rtl/ex_stage_alu_unit.sv
// Combinational RV32I ALU. Define ALU_EXT_OPS_EN to enable xor/sll/srl (codes 100/110/111);
// otherwise those codes yield 0.
module alu_unit
  import riscv_pkg::*;
#(
  parameter int unsigned XLEN = riscv_pkg::XLEN
) (
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  input  logic [2:0]      alu_control_i,
  output logic [XLEN-1:0] result_o,
  output logic            zero_o
);

  logic lt;

  always_comb begin
    lt       = $signed(a_i) < $signed(b_i);
    result_o = '0;
    case (alu_ctrl_t'(alu_control_i))
      ADD:     result_o = a_i + b_i;
      SUB:     result_o = a_i - b_i;
      AND:     result_o = a_i & b_i;
      OR:      result_o = a_i | b_i;
      SLT:     result_o = {{(XLEN-1){1'b0}}, lt};
`ifdef ALU_EXT_OPS_EN
      XOR:     result_o = a_i ^ b_i;
      SLL:     result_o = a_i << b_i[4:0];
      SRL:     result_o = a_i >> b_i[4:0];
`endif
      default: result_o = '0;
    endcase
    zero_o = (result_o == '0);
  end

endmodule

// File: rtl/ex_stage.sv
// RV32I execute stage: operand forwarding, ALU, beq/jal redirect and the EX/MEM register.
// ALU_EXT_OPS_EN (see alu_unit) enables the xor/sll/srl operations.
module ex_stage
  import riscv_pkg::*;
(
  input logic       clk,
  input logic       rst,
  ex_stage_if.slave bus
);

  logic [XLEN-1:0] src_a, fwd_b, src_b, alu_result;
  logic            alu_zero;
  exmem_t          exmem_d, exmem_q;

  always_comb begin
    src_a = fwd_mux(fwd_sel_t'(bus.forward_a_e), bus.rd1_e, bus.result_w, exmem_q.alu_result);
    fwd_b = fwd_mux(fwd_sel_t'(bus.forward_b_e), bus.rd2_e, bus.result_w, exmem_q.alu_result);
    src_b = bus.alu_src_e ? bus.imm_ext_e : fwd_b;
  end

  alu_unit #(
    .XLEN(XLEN)
  ) u_alu (
    .a_i          (src_a),
    .b_i          (src_b),
    .alu_control_i(bus.alu_control),
    .result_o     (alu_result),
    .zero_o       (alu_zero)
  );

  // Redirect is deliberately not gated by stall/flush; the hazard unit owns that decision.
  assign bus.pc_src_e    = bus.valid_e & (bus.jump_e | (bus.branch_e & alu_zero));
  assign bus.pc_target_e = bus.pc_e + bus.imm_ext_e;

  always_comb begin
    exmem_d = exmem_q;
    if (bus.flush) begin
      exmem_d = '0;
    end else if (!bus.stall) begin
      exmem_d.valid      = bus.valid_e;
      exmem_d.reg_write  = bus.valid_e & bus.reg_write_e;
      exmem_d.mem_write  = bus.valid_e & bus.mem_write_e;
      exmem_d.result_src = bus.result_src_e;
      exmem_d.alu_result = alu_result;
      exmem_d.write_data = fwd_b;
      exmem_d.pc_plus4   = bus.pc_plus4_e;
      exmem_d.rd         = bus.rd_e;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      exmem_q <= '0;
    end else begin
      exmem_q <= exmem_d;
    end
  end

  assign bus.valid_m      = exmem_q.valid;
  assign bus.reg_write_m  = exmem_q.reg_write;
  assign bus.mem_write_m  = exmem_q.mem_write;
  assign bus.result_src_m = exmem_q.result_src;
  assign bus.alu_result_m = exmem_q.alu_result;
  assign bus.write_data_m = exmem_q.write_data;
  assign bus.pc_plus4_m   = exmem_q.pc_plus4;
  assign bus.rd_m         = exmem_q.rd;

endmodule
